// File: rtl/reg32_ser_pkg.sv
// Shared definitions for the 32-bit register serializer.
// Optional parity bit selected by defining SER_PARITY_EN.
package reg32_ser_pkg;

   localparam int unsigned DATA_W       = 32;
   localparam int unsigned NBITS_PLAIN  = 32;
   localparam int unsigned NBITS_PARITY = 33;

`ifdef SER_PARITY_EN
   localparam int unsigned NBITS = NBITS_PARITY;
`else
   localparam int unsigned NBITS = NBITS_PLAIN;
`endif

   localparam int unsigned BITCNT_W = 6;
   localparam int unsigned DIVCNT_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD,
      ST_DONE
   } state_t;

`ifdef SER_PARITY_EN
   function automatic logic even_parity(input logic [DATA_W-1:0] i_data);
      return ^i_data;
   endfunction
`endif

endpackage

// File: rtl/reg32_ser_clkdiv.sv
// Phase-tick generator: one-cycle tick every CLK_DIV enabled cycles.
// Counter restarts from zero whenever the enable drops.
module reg32_ser_clkdiv
   import reg32_ser_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic i_clock,
   input  logic i_resetn,
   input  logic i_en,
   output logic o_tick
);

   localparam logic [DIVCNT_W-1:0] DIV_LAST = DIVCNT_W'(CLK_DIV - 1);

   logic [DIVCNT_W-1:0] r_cnt;
   logic                w_last;

   assign w_last = (r_cnt == DIV_LAST);
   assign o_tick = i_en && w_last;

   always_ff @(posedge i_clock) begin
      if (!i_resetn || !i_en) begin
         r_cnt <= '0;
      end else if (w_last) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + DIVCNT_W'(1);
      end
   end

endmodule

// File: rtl/reg32_serializer.sv
// Serializes a latched 32-bit register MSB first over cs_n/sclk/sdo.
// Defining SER_PARITY_EN appends an even-parity bit after bit 0.
module reg32_serializer
   import reg32_ser_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic [DATA_W-1:0] Q_in,
   input  logic              load,
   output logic              busy,
   output logic              done,
   output logic              cs_n,
   output logic              sclk,
   output logic              sdo
);

   localparam logic [BITCNT_W-1:0] BITS_LAST = BITCNT_W'(NBITS);

   state_t              r_state;
   logic [NBITS-1:0]    r_shift;
   logic [BITCNT_W-1:0] r_bitcnt;
   logic                r_busy;
   logic                r_done;
   logic                r_csn;
   logic                r_sclk;
   logic                r_sdo;

   logic                w_en;
   logic                w_tick;
   logic [NBITS-1:0]    w_frame;

`ifdef SER_PARITY_EN
   assign w_frame = {Q_in, even_parity(Q_in)};
`else
   assign w_frame = Q_in;
`endif

   assign w_en = (r_state == ST_SETUP) || (r_state == ST_SHIFT) || (r_state == ST_HOLD);

   reg32_ser_clkdiv #(
      .CLK_DIV (CLK_DIV)
   ) u_clkdiv (
      .i_clock  (clock),
      .i_resetn (resetn),
      .i_en     (w_en),
      .o_tick   (w_tick)
   );

   // sdo is reloaded only on the falling sclk phase, so it is stable across each high phase
   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_state  <= ST_IDLE;
         r_shift  <= '0;
         r_bitcnt <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_csn    <= 1'b1;
         r_sclk   <= 1'b0;
         r_sdo    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (load) begin
                  r_state  <= ST_SETUP;
                  r_shift  <= w_frame;
                  r_bitcnt <= '0;
                  r_busy   <= 1'b1;
                  r_csn    <= 1'b0;
                  r_sdo    <= w_frame[NBITS-1];
               end
            end
            ST_SETUP: begin
               if (w_tick) begin
                  r_state <= ST_SHIFT;
                  r_sclk  <= 1'b1;
               end
            end
            ST_SHIFT: begin
               if (w_tick) begin
                  if (r_sclk) begin
                     r_sclk   <= 1'b0;
                     r_shift  <= {r_shift[NBITS-2:0], 1'b0};
                     r_sdo    <= r_shift[NBITS-2];
                     r_bitcnt <= r_bitcnt + BITCNT_W'(1);
                  end else if (r_bitcnt == BITS_LAST) begin
                     r_state <= ST_HOLD;
                  end else begin
                     r_sclk <= 1'b1;
                  end
               end
            end
            ST_HOLD: begin
               if (w_tick) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_csn   <= 1'b1;
                  r_sdo   <= 1'b0;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign cs_n = r_csn;
   assign sclk = r_sclk;
   assign sdo  = r_sdo;

endmodule

// File: tb/tb_reg32_serializer.sv
// Self-checking bench for reg32_serializer (CLK_DIV=2 and CLK_DIV=255 instances).
// Follows SER_PARITY_EN to select the expected frame length.
module tb_reg32_serializer;

`ifdef SER_PARITY_EN
   localparam int N = 33;
`else
   localparam int N = 32;
`endif

   logic        clk = 1'b0;
   logic        resetn;
   logic [31:0] q_in;
   logic        load_a, load_b;
   logic        a_busy, a_done, a_csn, a_sclk, a_sdo;
   logic        b_busy, b_done, b_csn, b_sclk, b_sdo;
   logic        sel;
   logic        m_busy, m_done, m_csn, m_sclk, m_sdo;

   int          checks = 0;
   int          failures = 0;
   bit          bq[$];
   logic [32:0] last_got;

   always #5 clk = ~clk;

   reg32_serializer #(.CLK_DIV(2)) dut_a (
      .clock (clk), .resetn (resetn), .Q_in (q_in), .load (load_a),
      .busy (a_busy), .done (a_done), .cs_n (a_csn), .sclk (a_sclk), .sdo (a_sdo)
   );

   reg32_serializer #(.CLK_DIV(255)) dut_b (
      .clock (clk), .resetn (resetn), .Q_in (q_in), .load (load_b),
      .busy (b_busy), .done (b_done), .cs_n (b_csn), .sclk (b_sclk), .sdo (b_sdo)
   );

   assign m_busy = sel ? b_busy : a_busy;
   assign m_done = sel ? b_done : a_done;
   assign m_csn  = sel ? b_csn  : a_csn;
   assign m_sclk = sel ? b_sclk : a_sclk;
   assign m_sdo  = sel ? b_sdo  : a_sdo;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic set_load(input logic v);
      load_a = (sel == 1'b0) ? v : 1'b0;
      load_b = (sel == 1'b1) ? v : 1'b0;
   endtask

   task automatic chk(input string tag, input int c, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, c, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_vec(input string tag, input logic [32:0] obs, input logic [32:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected {cs_n, sclk, sdo, busy, done} for cycle c after acceptance (c<=0: idle).
   function automatic logic [4:0] model(input int d, input int c);
      int setup_end, shift_end, hold_end, k, i;
      logic csn_e, sclk_e, sdo_e, busy_e, done_e;
      setup_end = d;
      shift_end = d + 2 * N * d;
      hold_end  = shift_end + d;
      csn_e = 1'b1; sclk_e = 1'b0; sdo_e = 1'b0; busy_e = 1'b0; done_e = 1'b0;
      if (c >= 1 && c <= hold_end) begin
         csn_e  = 1'b0;
         busy_e = 1'b1;
      end
      if (c >= 1 && c <= setup_end) begin
         sdo_e = bq[0];
      end else if (c > setup_end && c <= shift_end) begin
         k = c - setup_end - 1;
         i = k / (2 * d);
         if ((k % (2 * d)) < d) begin
            sclk_e = 1'b1;
            sdo_e  = bq[i];
         end else begin
            sdo_e = (i + 1 < N) ? bq[i + 1] : 1'b0;
         end
      end
      if (c == hold_end + 1) done_e = 1'b1;
      return {csn_e, sclk_e, sdo_e, busy_e, done_e};
   endfunction

   task automatic check_cycle(input int d, input int c);
      logic [4:0] e;
      e = model(d, c);
      chk("cs_n", c, m_csn,  e[4]);
      chk("sclk", c, m_sclk, e[3]);
      chk("sdo",  c, m_sdo,  e[2]);
      chk("busy", c, m_busy, e[1]);
      chk("done", c, m_done, e[0]);
   endtask

   task automatic build_bits(input logic [31:0] q);
      bq.delete();
      for (int i = 31; i >= 0; i--) bq.push_back(q[i]);
`ifdef SER_PARITY_EN
      bq.push_back(^q);
`endif
   endtask

   // Called just after a negedge with the DUT idle; the next posedge accepts.
   task automatic run_frame(input logic which, input int d, input logic [31:0] q,
                            input bit hold, input bit poke);
      int          t;
      int          rises;
      int          done_at;
      logic        prev_sclk;
      logic [32:0] got;
      logic [32:0] exp_vec;
      build_bits(q);
      t = (2 * N + 2) * d + 1;
      sel = which;
      q_in = q;
      set_load(1'b1);
      rises = 0; done_at = -1; prev_sclk = 1'b0; got = '0;
      for (int c = 1; c <= t + 1; c++) begin
         @(negedge clk);
         check_cycle(d, c);
         if (m_sclk && !prev_sclk) begin
            got = {got[31:0], m_sdo};
            rises++;
         end
         prev_sclk = m_sclk;
         if (m_done && done_at < 0) done_at = c;
         if (!hold) begin
            if (poke && c == 10) begin
               set_load(1'b1);
               q_in = 32'hFFFF_FFFF;
            end else begin
               set_load(1'b0);
               q_in = $urandom;
            end
         end
      end
`ifdef SER_PARITY_EN
      exp_vec = {q, ^q};
`else
      exp_vec = {1'b0, q};
`endif
      chk_int("sclk_rises", rises, N);
      chk_int("done_cycle", done_at, t);
      chk_vec("frame_data", got, exp_vec);
      last_got = got;
   endtask

   task automatic reset_mid(input int d, input logic [31:0] q);
      int rc;
      build_bits(q);
      rc = 11 * d + 1;
      sel = 1'b0;
      q_in = q;
      set_load(1'b1);
      for (int c = 1; c <= rc; c++) begin
         @(negedge clk);
         check_cycle(d, c);
         set_load(1'b0);
         q_in = $urandom;
      end
      resetn = 1'b0;
      set_load(1'b1);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check_cycle(d, 0);
      end
      resetn = 1'b1;
      set_load(1'b0);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check_cycle(d, 0);
      end
   endtask

   initial begin
      resetn = 1'b0;
      q_in   = '0;
      sel    = 1'b0;
      load_a = 1'b0;
      load_b = 1'b0;
      build_bits(32'h0);
      repeat (3) @(negedge clk);
      sel = 1'b0;
      check_cycle(2, 0);
      sel = 1'b1;
      check_cycle(255, 0);
      resetn = 1'b1;
      sel = 1'b0;
      @(negedge clk);
      check_cycle(2, 0);

      run_frame(1'b0, 2, 32'hA5A5_0F0F, 1'b0, 1'b0);
`ifdef SER_PARITY_EN
      chk("parity_A5A50F0F", 0, last_got[0], 1'b0);
`endif
      run_frame(1'b0, 2, 32'h0000_0001, 1'b0, 1'b0);
`ifdef SER_PARITY_EN
      chk("parity_00000001", 0, last_got[0], 1'b1);
`endif
      for (int k = 0; k < 4; k++) run_frame(1'b0, 2, $urandom, 1'b0, 1'b0);

      run_frame(1'b0, 2, 32'hA5A5_0F0F, 1'b0, 1'b1);

      reset_mid(2, $urandom);
      run_frame(1'b0, 2, $urandom, 1'b0, 1'b0);

      run_frame(1'b0, 2, 32'h1234_5678, 1'b1, 1'b0);
      run_frame(1'b0, 2, 32'h1234_5678, 1'b1, 1'b0);
      run_frame(1'b0, 2, 32'h1234_5678, 1'b0, 1'b0);

      run_frame(1'b1, 255, 32'h8000_0000, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
